// File: rtl/seq_shifter_if.sv
// Shift-unit request/response bundle: start/op/data_in/shamt in, busy/done/result out.
// Latency: none, wires only.
// Backpressure: requester must watch busy; start is ignored while busy=1.
//
// Ports (signals):
//   start    request strobe, sampled by the shifter only when idle
//   op       2-bit shift kind (00 SLL, 01 SRL, 10 SRA, 11 ROR or SLL)
//   data_in  operand, captured with start
//   shamt    shift amount 0..WIDTH-1, captured with start
//   busy     shift in progress
//   done     one-cycle completion pulse
//   result   last completed result, held between completions
interface seq_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter moving up to STEP bit positions per clock.
// Latency: done pulses after edge E_L, L = max(1, ceil(shamt/STEP)) past the accept edge E0.
// Backpressure: start ignored while busy; a start in the done cycle is accepted.
//
// Ports: clk (rising edge), reset (synchronous, active high), bus (seq_shifter_if.slave:
//   start/op/data_in/shamt request, busy/done/result response).
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN -- when defined op=11 rotates right,
//   otherwise op=11 behaves as SLL and no rotate path exists.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         reset,
    seq_shifter_if.slave bus
);
    // One extra bit so STEP (which may equal WIDTH) compares against rem without overflow.
    localparam int CMP_W = SHAMT_W + 1;
    localparam logic [CMP_W-1:0] STEP_C = CMP_W'(STEP);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   acc, acc_nx;
    logic [WIDTH-1:0]   result_q, result_nx;
    logic [SHAMT_W-1:0] rem, rem_nx;
    logic [1:0]         op_q, op_nx;
    logic               sign_q, sign_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;

    logic               last;
    logic [SHAMT_W-1:0] k;
    logic               right_op;
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH-1:0]   shifted;

    // Final step when what remains fits in one cycle; otherwise rem > STEP, so STEP fits rem's width.
    assign last = ({1'b0, rem} <= STEP_C);
    assign k    = last ? rem : SHAMT_W'(STEP);

    // Right shifts run through a double-width word whose upper half supplies the fill:
    // zeros for SRL, the captured sign for SRA, and a copy of acc for rotate.
    always_comb begin
        ext      = {{WIDTH{1'b0}}, acc};
        right_op = 1'b0;
        case (op_q)
            2'b01: right_op = 1'b1;
            2'b10: begin
                right_op = 1'b1;
                ext      = {{WIDTH{sign_q}}, acc};
            end
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11: begin
                right_op = 1'b1;
                ext      = {acc, acc};
            end
`endif
            default: right_op = 1'b0;
        endcase
        shifted = acc << k;
        if (right_op) begin
            shifted = WIDTH'(ext >> k);
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        rem_nx    = rem;
        op_nx     = op_q;
        sign_nx   = sign_q;
        busy_nx   = busy_q;
        done_nx   = 1'b0;
        result_nx = result_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nx   = bus.data_in;
                    rem_nx   = bus.shamt;
                    op_nx    = bus.op;
                    sign_nx  = bus.data_in[WIDTH-1];
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                acc_nx = shifted;
                rem_nx = rem - k;
                if (last) begin
                    state_nx  = IDLE;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                    result_nx = shifted;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            rem      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            rem      <= rem_nx;
            op_q     <= op_nx;
            sign_q   <= sign_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            result_q <= result_nx;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: one STEP=1 and one STEP=4 instance, directed cases then random ops.
// Latency: expected completion cycle derived from shamt and STEP.
// Backpressure: exercises ignored start while busy and back-to-back start in the done cycle.
module tb_seq_shifter;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(WIDTH)) if1 ();
    seq_shifter_if #(.WIDTH(WIDTH)) if4 ();

    seq_shifter #(.WIDTH(WIDTH), .STEP(1)) u_s1 (.clk(clk), .reset(reset), .bus(if1));
    seq_shifter #(.WIDTH(WIDTH), .STEP(4)) u_s4 (.clk(clk), .reset(reset), .bus(if4));

    // Stimulus: both instances see the same operand; start goes only to the selected one.
    int          sel = 0;
    logic        st  = 1'b0;
    logic [1:0]  opv = 2'b00;
    logic [31:0] dv  = '0;
    logic [4:0]  shv = '0;

    assign if1.start   = st && (sel == 0);
    assign if4.start   = st && (sel == 1);
    assign if1.op      = opv;
    assign if4.op      = opv;
    assign if1.data_in = dv;
    assign if4.data_in = dv;
    assign if1.shamt   = shv;
    assign if4.shamt   = shv;

    logic        o_busy, o_done;
    logic [31:0] o_result;
    always_comb begin
        o_busy   = (sel == 1) ? if4.busy   : if1.busy;
        o_done   = (sel == 1) ? if4.done   : if1.done;
        o_result = (sel == 1) ? if4.result : if1.result;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the shift as plain arithmetic on the whole operand.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int sh);
        logic [31:0] r;
        case (o)
            2'b00: r = d << sh;
            2'b01: r = d >> sh;
            2'b10: r = $unsigned($signed(d) >>> sh);
            default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
                r = (d >> sh) | (d << (32 - sh));
`else
                r = d << sh;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int latency(input int sh);
        int step;
        step = (sel == 1) ? 4 : 1;
        return (sh == 0) ? 1 : (sh + step - 1) / step;
    endfunction

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic start_op(input logic [1:0] o, input logic [31:0] d, input int sh);
        st  = 1'b1;
        opv = o;
        dv  = d;
        shv = 5'(sh);
        @(posedge clk);
        @(negedge clk);
        st  = 1'b0;
        opv = 2'($urandom);
        dv  = $urandom;
        shv = 5'($urandom);
        chk("busy_after_accept", {31'b0, o_busy}, 32'd1);
        chk("done_after_accept", {31'b0, o_done}, 32'd0);
    endtask

    // Walks cycles E1..E_L checking busy/done/result; optionally fires a start that must be ignored.
    task automatic wait_done(input logic [1:0] o, input logic [31:0] d, input int sh, input int inj);
        int l;
        logic [31:0] exp;
        l   = latency(sh);
        exp = model(o, d, sh);
        for (int i = 1; i <= l; i++) begin
            @(negedge clk);
            st = 1'b0;
            chk("done_timing", {31'b0, o_done}, (i == l) ? 32'd1 : 32'd0);
            chk("busy_timing", {31'b0, o_busy}, (i < l) ? 32'd1 : 32'd0);
            chk((i == l) ? "result" : "result_held", o_result, (i == l) ? exp : last_res[sel]);
            if (i + 1 == inj) begin
                st  = 1'b1;
                opv = 2'b01;
                dv  = $urandom;
                shv = 5'd1;
            end
        end
        last_res[sel] = exp;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk(tag, {30'b0, o_busy, o_done}, 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rd;
        int          rs;

        last_res[0] = '0;
        last_res[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("reset_busy", {31'b0, o_busy}, 32'd0);
            chk("reset_done", {31'b0, o_done}, 32'd0);
            chk("reset_result", o_result, 32'd0);
        end

        // STEP=1 SLL 1 by 2.
        sel = 0;
        start_op(2'b00, 32'h0000_0001, 2);
        wait_done(2'b00, 32'h0000_0001, 2, 0);
        idle_check("sll_pulse_end");

        // STEP=4 SRA and SRL of 0x8000_0000 by 31.
        sel = 1;
        start_op(2'b10, 32'h8000_0000, 31);
        wait_done(2'b10, 32'h8000_0000, 31, 0);
        idle_check("sra_pulse_end");
        start_op(2'b01, 32'h8000_0000, 31);
        wait_done(2'b01, 32'h8000_0000, 31, 0);
        idle_check("srl_pulse_end");

        // shamt=0, then a start in the done cycle.
        start_op(2'b01, 32'hDEAD_BEEF, 0);
        wait_done(2'b01, 32'hDEAD_BEEF, 0, 0);
        start_op(2'b00, 32'h0000_0003, 5);
        wait_done(2'b00, 32'h0000_0003, 5, 0);
        idle_check("b2b_pulse_end");

        // STEP=1: start pulsed at E3 while busy must be ignored.
        sel = 0;
        start_op(2'b00, 32'h0000_0001, 10);
        wait_done(2'b00, 32'h0000_0001, 10, 3);
        idle_check("ignored_start_single_done");
        idle_check("ignored_start_still_idle");

        // op=11 (rotate right or SLL depending on build).
        sel = 1;
        start_op(2'b11, 32'h0000_00F1, 4);
        wait_done(2'b11, 32'h0000_00F1, 4, 0);
        idle_check("op11_pulse_end");

        // Reset at E5 aborts an in-flight SRL.
        sel = 0;
        start_op(2'b01, 32'hFFFF_FFFF, 20);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("pre_reset_busy", {31'b0, o_busy}, 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, o_busy}, 32'd0);
        chk("abort_done", {31'b0, o_done}, 32'd0);
        chk("abort_result", o_result, 32'd0);
        last_res[0] = '0;
        last_res[1] = '0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'b0, o_done}, 32'd0);
        end
        sel = 1;
        #0;
        chk("abort_result_step4", o_result, 32'd0);

        // Random operations on both instances, sometimes back-to-back.
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 1));
            ro  = 2'($urandom);
            rd  = $urandom;
            rs  = int'($urandom_range(0, 31));
            start_op(ro, rd, rs);
            wait_done(ro, rd, rs, 0);
            if ($urandom_range(0, 1) == 1) begin
                idle_check("rand_idle_gap");
            end
        end
        idle_check("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shift unit: the successor to the fixed left-shift-by-2 used on the branch-offset path. It supports logical left, logical right and arithmetic right shifts by a runtime amount, processing up to STEP bit positions per clock. It sits beside the ALU in the datapath for SLL/SRL/SRA-class instructions and communicates through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; at least 2.
- STEP, 1: bit positions shifted per cycle; a power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 see Configuration.
- data_in  input  WIDTH  operand; sampled with start.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; sampled with start.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when result updates.
- result  output  WIDTH  last completed result; held until the next completion.

## Operation
- Two states: IDLE and SHIFT. Internal registers: acc (WIDTH), rem (SHAMT_W), op_q, sign_q.
- IDLE with start=1: acc<=data_in, rem<=shamt, op_q<=op, sign_q<=data_in[WIDTH-1], busy<=1, state<=SHIFT.
- SHIFT, every edge: k=min(STEP, rem). acc is shifted by k per op_q. rem<=rem-k.
  - If rem<=STEP before the edge: state<=IDLE, busy<=0, done<=1, result<=shifted acc.
- SLL and SRL fill with zeros. SRA fills with sign_q, so the fill bit does not depend on intermediate acc values.
- start while busy=1 is ignored; no queueing.
- start in the cycle done=1 is accepted, because the state is already IDLE.
- data_in, op and shamt are don't-care outside the accepting cycle.
- result and done change only on completion or reset.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE, acc=0, rem=0.
- Reset asserted mid-operation aborts it at that edge. No done pulse follows.
- Accept edge E0. done is high for exactly the one cycle following edge E_L, where L = max(1, ceil(shamt/STEP)).
- Examples:
  - shamt=0: done after E1, and result equals data_in.
  - STEP=1, shamt=31: done after E31.
  - STEP=4, shamt=31: done after E8.
- busy rises after E0 and falls after E_L, in the same cycle done rises.
- Throughput: a new start is accepted in the done cycle, so back-to-back operations have no idle gap.

## Configuration
- SEQ_SHIFTER_ROTATE_EN defined:
  - op=11 is rotate right. Bits shifted out at the LSB re-enter at the MSB.
  - Latency is the same as for the other ops.
- SEQ_SHIFTER_ROTATE_EN undefined:
  - op=11 behaves exactly as SLL.
  - No rotate logic is synthesised.

## Test plan
- WIDTH=32, STEP=1: start with op=SLL, data_in=0x0000_0001, shamt=2. Required: result=0x0000_0004, done after E2, busy high for 2 cycles.
- WIDTH=32, STEP=4: op=SRA, data_in=0x8000_0000, shamt=31. Required: result=0xFFFF_FFFF, done after E8. Repeat with op=SRL. Required: result=0x0000_0001.
- shamt=0, op=SRL, data_in=0xDEAD_BEEF. Required: result=0xDEAD_BEEF, done after E1. Then issue a second start in the done cycle. Required: it is accepted.
- STEP=1: accept SLL of 0x1 with shamt=10, then pulse start with new data at E3. Required: the second start is ignored, result=0x0000_0400 after E10, and a single done pulse.
- Start SRL of 0xFFFF_FFFF with shamt=20, then assert reset at E5. Required: busy=0, done=0 and result=0 after the edge, and no later done pulse.
- With SEQ_SHIFTER_ROTATE_EN defined: op=11, data_in=0x0000_00F1, shamt=4. Required: result=0x1000_000F. Without the macro: result=0x0000_0F10.
